// File: rtl/serial_deframer.sv
// serial_deframer: LSB-first serial-to-parallel receiver with a small output
// FIFO, valid/ready drain and a sticky overflow flag for dropped words.
module serial_deframer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     in,
  input  logic                     en,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IW-1:0]                 idx;
  logic [WIDTH-1:0]              sreg;
  logic [WIDTH-1:0]              word;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic                          last_bit, pop, push, drop;

  // The last bit goes straight into the completed word so it can be
  // pushed on the same edge that samples it.
  always_comb begin
    word           = sreg;
    word[WIDTH-1]  = in;
  end

  assign last_bit = en && (idx == IW'(WIDTH - 1));
  assign pop      = q_valid && q_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push     = last_bit && (!full || pop);
  assign drop     = last_bit && full && !pop;

  // Bit assembly: write the sampled bit at idx, wrap idx after the MSB.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx  <= '0;
      sreg <= '0;
    end else if (en) begin
      sreg[idx] <= in;
      idx       <= last_bit ? '0 : idx + IW'(1);
    end
  end

  // FIFO storage; stale contents are harmless because q is masked when empty.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= word;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: any completed word that could not be stored.
  always_ff @(posedge clk) begin
    if (clear)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  // Outputs come from registered state only.
  assign q_valid = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign q       = q_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: stimulus queues expected words,
// a negedge monitor compares every handshake pop against the queue.
module tb_serial_deframer;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       ser_in = 1'b0;
  logic       en = 1'b0;
  logic       q_ready = 1'b0;
  logic [7:0] q;
  logic       q_valid, full, overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int maxcnt = 0;
  logic [7:0] expq[$];

  serial_deframer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .clear(clear), .in(ser_in), .en(en),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expq.delete();
  endtask

  task automatic send_word(input logic [7:0] w, input bit exp_push,
                           input int max_gap, input bit pop_last);
    if (exp_push) expq.push_back(w);
    for (int i = 0; i < 8; i++) begin
      if (pop_last && i == 7) q_ready = 1'b1;
      en     = 1'b1;
      ser_in = w[i];
      tick();
      if (pop_last && i == 7) q_ready = 1'b0;
      en = 1'b0;
      if (max_gap > 0 && i < 7)
        repeat ($urandom_range(0, max_gap)) begin
          ser_in = ~ser_in;
          tick();
        end
    end
  endtask

  task automatic drain(input int n);
    q_ready = 1'b1;
    repeat (n) tick();
    q_ready = 1'b0;
  endtask

  // Monitor: a pop happens on the next posedge whenever valid && ready now.
  always @(negedge clk) begin
    if (int'(count) > maxcnt) maxcnt = int'(count);
    if (!clear && q_valid && q_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", q);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        if (q !== e) begin
          errors++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", q, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] w1;
    // Reset state
    do_clear();
    chk("rst_q_valid", q_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_q", q, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);

    // Single word 0xCC, no early valid
    w1 = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1;
      ser_in = w1[i];
      tick();
      if (i < 7) chk("single_early_valid", q_valid, 0);
    end
    en = 1'b0;
    chk("single_valid", q_valid, 1);
    chk("single_q", q, 8'hCC);
    chk("single_count", count, 1);

    // Fill and overflow
    do_clear();
    send_word(8'hCC, 1, 0, 0);
    send_word(8'hAA, 1, 0, 0);
    send_word(8'hCC, 1, 0, 0);
    send_word(8'hAA, 1, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    send_word(8'h55, 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_q", q, 8'hCC);
    chk("ovf_count", count, 4);
    drain(4);
    chk("ovf_drained_valid", q_valid, 0);
    chk("ovf_drained_q", q, 0);
    chk("ovf_sticky", overflow, 1);

    // en gating with toggling input while disabled
    do_clear();
    chk("clear_ovf", overflow, 0);
    send_word(8'hAA, 1, 3, 0);
    chk("gate_q", q, 8'hAA);
    chk("gate_count", count, 1);
    drain(1);

    // Simultaneous push/pop at full
    do_clear();
    send_word(8'h11, 1, 0, 0);
    send_word(8'h22, 1, 0, 0);
    send_word(8'h44, 1, 0, 0);
    send_word(8'h88, 1, 0, 0);
    send_word(8'h33, 1, 0, 1);
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    chk("pp_q", q, 8'h22);
    drain(4);
    chk("pp_empty", q_valid, 0);

    // Clear mid-operation
    do_clear();
    send_word(8'h0F, 1, 0, 0);
    send_word(8'hF0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      en = 1'b1;
      ser_in = 1'b1;
      tick();
    end
    en = 1'b0;
    do_clear();
    chk("mid_count", count, 0);
    chk("mid_valid", q_valid, 0);
    chk("mid_overflow", overflow, 0);
    send_word(8'hAA, 1, 0, 0);
    chk("mid_q", q, 8'hAA);
    chk("mid_count_after", count, 1);
    drain(1);

    // Wrap-around with continuous ready
    do_clear();
    maxcnt = 0;
    q_ready = 1'b1;
    for (int k = 1; k <= 10; k++) send_word(8'(k), 1, 0, 0);
    tick();
    tick();
    q_ready = 1'b0;
    chk("wrap_maxcnt_le1", (maxcnt <= 1) ? 1 : 0, 1);
    chk("wrap_overflow", overflow, 0);
    chk("wrap_empty", q_valid, 0);
    chk("wrap_queue_left", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Serial-to-parallel receiver placed directly downstream of the memory/counter/8:1-mux serial bit generator. It samples one serial bit per enabled clock, LSB first, and assembles WIDTH-bit words. It buffers completed words in a small FIFO and presents them to the next stage through a valid/ready handshake. It flags any word lost to a full buffer with a sticky overflow flag.

## Interface
- WIDTH, 8: bits per assembled word; serial order is LSB first (bit 0 received first).
- DEPTH, 4: FIFO entries; must be a power of two, minimum 2.
- clk  input  1  clock; all state changes on posedge.
- clear  input  1  reset; synchronous, active-high. Sampled on posedge clk.
- in  input  1  serial data bit, sampled on posedge clk when en=1.
- en  input  1  bit strobe; in is ignored when en=0.
- q  output  WIDTH  word at FIFO head; 0 when FIFO empty.
- q_valid  output  1  FIFO non-empty.
- q_ready  input  1  consumer accepts q this cycle.
- full  output  1  count == DEPTH.
- count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a completed word is dropped.

## Operation
- Bit assembly:
  - Bit index counter idx, 0..WIDTH-1.
  - On posedge with en=1, in is written to shift-register position idx.
  - idx then increments, and wraps from WIDTH-1 to 0.
  - When en=0, idx and the shift register hold.
- Word completion:
  - Occurs on an enabled edge with idx==WIDTH-1.
  - The completed word is the WIDTH-1 previously stored bits with the current in as the MSB, formed in the same cycle.
  - The completed word is the push candidate on that edge.
- Pop: occurs on an edge where q_valid=1 and q_ready=1. It advances the read pointer. q_ready while empty has no effect.
- Push acceptance: push is accepted if count<DEPTH, or if a pop occurs on the same edge.
- Overflow:
  - A push candidate with count==DEPTH and no same-edge pop is dropped. FIFO contents are unchanged.
  - Dropping a word sets overflow=1. overflow stays set until clear.
- Occupancy:
  - Read and write pointers wrap modulo DEPTH.
  - count = previous count + push_accepted − pop.
  - With a simultaneous accepted push and pop, count is unchanged. This holds at both empty and full.
- Empty FIFO: the FIFO has no bypass. A word pushed into an empty FIFO is popped no earlier than the following edge.
- Clear:
  - Asserting clear mid-word discards partial bits. The next enabled bit after clear is bit 0.
  - Clear empties the FIFO and clears overflow.
  - Clear has priority over en, push and pop on the same edge.

## Timing
- Values after an edge with clear=1:
  - idx=0, shift register=0, pointers=0.
  - count=0, q_valid=0, q=0, full=0, overflow=0.
- Latency: q_valid rises on the edge that captures the last bit (bit WIDTH-1). The word is visible on q after that edge, one edge after the last bit's sample edge would be too late. Throughput is one word per WIDTH enabled cycles.
- Output derivation: q, q_valid, full and count are functions of registered state only, with no combinational path from in, en or q_ready.
  - q = mem[rd_ptr] when count>0, else 0.
- Sustained input: with en=1 continuously and q_ready=1 continuously, count never exceeds 1.

## Test plan
- Single word:
  - Stimulus: clear for 1 cycle, then en=1 with in = 0,0,1,1,0,0,1,1 (0xCC, LSB first), q_ready=0.
  - Required response: after the 8th edge, q_valid=1, q=0xCC, count=1. q_valid was 0 after edges 1–7.
- Fill and overflow:
  - Stimulus: stream 0xCC, 0xAA, 0xCC, 0xAA with q_ready=0, then stream 0x55.
  - Required response after 4 words: full=1, count=4.
  - Required response after 0x55: 0x55 is dropped, overflow=1, q=0xCC.
  - Then pulse q_ready once per cycle: pops return 0xCC, 0xAA, 0xCC, 0xAA, then q_valid=0 and q=0. overflow stays 1.
- en gating:
  - Stimulus: send 0xAA with en=0 on random cycles between bits, with in toggling while en=0.
  - Required response: q=0xAA and count=1.
- Simultaneous push/pop at full:
  - Stimulus: fill to 4, then hold q_ready=1 on the edge completing a 5th word 0x33.
  - Required response: count stays 4, overflow=0, and 0x33 emerges 4th after the remaining words.
- Clear mid-operation:
  - Stimulus: with 2 words buffered and 5 bits of a third received, assert clear for 1 cycle.
  - Required response: count=0, q_valid=0, overflow=0.
  - Then feed the 8 bits of 0xAA: q=0xAA, with no stale bits.
- Wrap-around:
  - Stimulus: stream 10 words, 0x01..0x0A, with q_ready=1 throughout.
  - Required response: words are popped in order 0x01..0x0A, count ≤1 at all times, overflow=0, and the pointers wrap at least twice.
